// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_pkg
// Description : Shared types and constants for the instruction fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

    localparam int c_WORD_BYTES = 4;
    localparam int c_OPCODE_MSB = 31;
    localparam int c_OPCODE_LSB = 26;
    localparam int c_FUNCT_MSB  = 5;
    localparam int c_FUNCT_LSB  = 0;

    // Branch immediate is a signed word offset; scale to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_sel
// Description : Combinational next-PC selection from decoder redirect flags.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic        jumptoreg,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] w_pcplus4;
    logic        w_unused_opcode;

    assign w_pcplus4       = pc + 32'(c_WORD_BYTES);
    assign w_unused_opcode = ^instr[c_OPCODE_MSB:c_OPCODE_LSB];

    always_comb begin
        next_pc = w_pcplus4;
        if (jumptoreg) begin
            next_pc = rs_data;
        end else if (jump) begin
            next_pc = {w_pcplus4[31:28], instr[25:0], 2'b00};
        end else if (pcsrc) begin
            next_pc = w_pcplus4 + branch_offset(instr[15:0]);
        end
    end

    // Only a register target can land off a word boundary.
    assign misaligned = jumptoreg && (rs_data[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : PC register, imem request/ready handshake and decode handoff.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic        jumptoreg,
    input  logic [31:0] rs_data,
    output logic        fetch_err
);

    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [7:0]   r_wait_cnt;
    logic [31:0]  w_next_pc;
    logic         w_misaligned;
    logic         w_retire;

    next_pc_sel u_next_pc_sel (
        .pc         (r_pc),
        .instr      (r_instr),
        .rs_data    (rs_data),
        .pcsrc      (pcsrc),
        .jump       (jump),
        .jumptoreg  (jumptoreg),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_err   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_state_nxt = VALID;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt = ERR;
                end
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (w_misaligned) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_state_nxt = FETCH;
                        w_retire    = 1'b1;
                    end
                end
            end
            ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // PC only advances on a clean retire; an error retire leaves it pointing
    // at the offending instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0000_0000;
            r_wait_cnt <= 8'd0;
        end else begin
            if (r_state == FETCH) begin
                if (imem_ready) begin
                    r_instr    <= imem_rdata;
                    r_wait_cnt <= 8'd0;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
            end
            if (w_retire) begin
                r_pc <= w_next_pc;
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign pcplus4   = r_pc + 32'(c_WORD_BYTES);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit (fetch addresses, redirects).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int          c_TIMEOUT  = 4;
    localparam logic [31:0] c_NOP      = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pcsrc;
    logic        jump;
    logic        jumptoreg;
    logic [31:0] rs_data;
    logic        fetch_err;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    fetch_unit #(
        .RESET_PC (c_RESET_PC),
        .TIMEOUT  (c_TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .jumptoreg   (jumptoreg),
        .rs_data     (rs_data),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                               input logic [31:0] rs, input logic br,
                                               input logic j, input logic jr);
        logic [31:0]        p4;
        logic signed [31:0] off;
        p4  = cur_pc + 32'd4;
        off = 32'(signed'(ins[15:0]));
        if (jr) return rs;
        if (j)  return {p4[31:28], ins[25:0], 2'b00};
        if (br) return p4 + 32'(off * 4);
        return p4;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_req",   imem_req,    0);
        check("rst_valid", instr_valid, 0);
        check("rst_err",   fetch_err,   0);
        check("rst_pc",    pc,          c_RESET_PC);
        check("rst_addr",  imem_addr,   c_RESET_PC);
        check("rst_instr", instr,       32'h0);
        step();
        reset      = 1'b0;
        imem_ready = 1'b0;
        check("idle_noreq", imem_req, 0);
        step();
        check("first_req", imem_req, 1);
        sb_q.delete();
        sb_q.push_back(c_RESET_PC);
    endtask

    // Entered with the DUT in FETCH; memory answers after 'waits' idle cycles.
    task automatic fetch_one(input logic [31:0] rdata, input int waits);
        logic [31:0] a0;
        logic [31:0] exp_addr;
        a0 = imem_addr;
        for (int i = 0; i < waits; i++) begin
            check("req_hold",    imem_req,  1);
            check("addr_stable", imem_addr, a0);
            check("no_err_wait", fetch_err, 0);
            imem_ready = 1'b0;
            step();
        end
        check("req_at_ready", imem_req,  1);
        check("addr_stable",  imem_addr, a0);
        check("sb_depth",     32'(sb_q.size()), 32'd1);
        exp_addr = a0;
        if (sb_q.size() > 0) exp_addr = sb_q.pop_front();
        check("fetch_addr", imem_addr, exp_addr);
        imem_ready = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("valid",    instr_valid, 1);
        check("req_drop", imem_req,    0);
        check("instr",    instr,       rdata);
        check("pc",       pc,          exp_addr);
        check("pcplus4",  pcplus4,     exp_addr + 32'd4);
        m_pc    = exp_addr;
        m_instr = rdata;
    endtask

    task automatic retire(input logic br, input logic j, input logic jr,
                          input logic [31:0] rs, input int stall);
        logic [31:0] nxt;
        logic        bad;
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            pcsrc       = 1'b1;
            jump        = 1'b1;
            jumptoreg   = 1'b1;
            rs_data     = 32'h0000_0777;
            step();
            check("stall_valid", instr_valid, 1);
            check("stall_instr", instr,       m_instr);
            check("stall_pc",    pc,          m_pc);
            check("stall_noreq", imem_req,    0);
        end
        nxt = model_next(m_pc, m_instr, rs, br, j, jr);
        bad = (nxt[1:0] != 2'b00);
        if (!bad) sb_q.push_back(nxt);
        pcsrc       = br;
        jump        = j;
        jumptoreg   = jr;
        rs_data     = rs;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        jump        = 1'b0;
        jumptoreg   = 1'b0;
        rs_data     = 32'h0;
        if (bad) begin
            check("err_flag",    fetch_err,   1);
            check("err_noreq",   imem_req,    0);
            check("err_novalid", instr_valid, 0);
            check("err_pc_held", pc,          m_pc);
        end else begin
            check("refetch_req",    imem_req,    1);
            check("retire_novalid", instr_valid, 0);
            check("no_err",         fetch_err,   0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b0;
        pcsrc       = 1'b0;
        jump        = 1'b0;
        jumptoreg   = 1'b0;
        rs_data     = 32'h0;
        m_pc        = 32'h0;
        m_instr     = 32'h0;
        do_reset();

        // Zero-wait sequential fetch: 0, 4, 8, C
        for (int k = 0; k < 4; k++) begin
            fetch_one(c_NOP | (32'(k) << 11), 0);
            retire(1'b0, 1'b0, 1'b0, 32'h0, 0);
        end

        // Slow memory at 0x10, then register jump to 0x40
        fetch_one(c_NOP, 3);
        retire(1'b0, 1'b0, 1'b1, 32'h0000_0040, 0);

        // Backward branch, then jump beating branch
        fetch_one(32'h1000_FFFE, 0);
        retire(1'b1, 1'b0, 1'b0, 32'h0, 0);
        fetch_one(32'h0800_0100, 0);
        retire(1'b1, 1'b1, 1'b0, 32'h0, 0);

        // Stall with noise on redirect inputs, then jumptoreg beating jump
        fetch_one(c_NOP, 0);
        retire(1'b0, 1'b1, 1'b1, 32'h0000_1000, 5);

        // Misaligned register target -> sticky error
        fetch_one(c_NOP, 0);
        retire(1'b0, 1'b0, 1'b1, 32'h0000_1002, 0);
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_sticky", fetch_err, 1);
            check("err_idle",   imem_req,  0);
            check("err_pc",     pc,        32'h0000_1000);
        end
        imem_ready = 1'b0;
        do_reset();

        // PC wrap at top of address space
        fetch_one(c_NOP, 0);
        retire(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 0);
        fetch_one(c_NOP, 1);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 0);
        fetch_one(c_NOP, 0);
        retire(1'b0, 1'b0, 1'b1, 32'h0000_0020, 0);

        // Reset while a request at 0x20 is outstanding
        check("mid_addr", imem_addr, 32'h0000_0020);
        step();
        step();
        check("mid_req", imem_req, 1);
        do_reset();

        // No ready ever: error after TIMEOUT fetch cycles
        for (int i = 0; i < c_TIMEOUT - 1; i++) begin
            step();
            check("to_wait_err", fetch_err, 0);
            check("to_wait_req", imem_req,  1);
        end
        step();
        check("to_err",   fetch_err, 1);
        check("to_noreq", imem_req,  0);
        do_reset();

        fetch_one(c_NOP, 0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 0);
        fetch_one(c_NOP, 2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
